// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressed RV32 data memory behind a request/response handshake.
// Handles SB/SH/SW stores with lane enables and LB/LH/LW/LBU/LHU loads. Read
// latency is configurable. Misaligned, illegal-funct3 and out-of-range accesses
// are rejected with an error response.
// Ports:
//   i_clk, i_rst_n       clock (rising edge), async active-low reset
//   i_req, i_we          request valid, 1 = store / 0 = load
//   i_addr, i_wdata      byte address, low-aligned store data
//   i_funct3             RV32 load/store funct3
//   o_ready              block is idle and will accept a request
//   o_resp_valid         one-cycle response strobe (loads and stores)
//   o_resp_err           access rejected (qualified by o_resp_valid)
//   o_rdata              load result (qualified by o_resp_valid)
module dmem_ctrl #(
    parameter int unsigned MEM_SIZE_KB  = 1,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_funct3,
    output logic        o_ready,
    output logic        o_resp_valid,
    output logic        o_resp_err,
    output logic [31:0] o_rdata
);

    localparam int unsigned DEPTH = MEM_SIZE_KB * 256;
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 2;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (READ_LATENCY > 1) ? CNT_W'(READ_LATENCY - 2) : '0;

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("dmem_ctrl: READ_LATENCY must be in 1..4");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_q, ready_d;
    logic               resp_valid_q, resp_valid_d;
    logic               resp_err_q, resp_err_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [31:0]        pipe_data_q, pipe_data_d;
    logic               pipe_err_q, pipe_err_d;

    logic [31:0]        mem_q [DEPTH];

    logic               accept_c;
    logic [IDX_W-1:0]   idx_c;
    logic [1:0]         off_c;
    logic [31:0]        rword_c;
    logic               f3_ok_c;
    logic               misaligned_c;
    logic               out_of_range_c;
    logic               err_c;
    logic [3:0]         be_c;
    logic [31:0]        wlanes_c;
    logic [7:0]         byte_c;
    logic [15:0]        half_c;
    logic [31:0]        load_c;
    logic [31:0]        result_c;
    logic               wr_en_c;

    assign accept_c = i_req & ready_q;
    assign idx_c    = i_addr[IDX_W+1:2];
    assign off_c    = i_addr[1:0];
    assign rword_c  = mem_q[idx_c];

    // Access legality, evaluated on the request currently presented.
    always_comb begin
        f3_ok_c        = i_we ? (i_funct3 inside {3'b000, 3'b001, 3'b010})
                              : (i_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misaligned_c   = ((i_funct3[1:0] == 2'b01) && off_c[0]) ||
                         ((i_funct3[1:0] == 2'b10) && (off_c != 2'b00));
        out_of_range_c = ((i_addr >> (IDX_W + 2)) != 32'd0) || (32'(idx_c) >= DEPTH);
        err_c          = !f3_ok_c || misaligned_c || out_of_range_c;
    end

    // Store lane enables and lane-replicated write data.
    always_comb begin
        be_c     = 4'b1111;
        wlanes_c = i_wdata;
        case (i_funct3[1:0])
            2'b00: begin
                be_c     = 4'b0001 << off_c;
                wlanes_c = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                be_c     = 4'b0011 << off_c;
                wlanes_c = {2{i_wdata[15:0]}};
            end
            default: begin
                be_c     = 4'b1111;
                wlanes_c = i_wdata;
            end
        endcase
    end

    // Load extraction and sign/zero extension.
    always_comb begin
        case (off_c)
            2'd0:    byte_c = rword_c[7:0];
            2'd1:    byte_c = rword_c[15:8];
            2'd2:    byte_c = rword_c[23:16];
            default: byte_c = rword_c[31:24];
        endcase
        half_c = off_c[1] ? rword_c[31:16] : rword_c[15:0];
        case (i_funct3)
            3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
            3'b100:  load_c = {24'd0, byte_c};
            3'b001:  load_c = {{16{half_c[15]}}, half_c};
            3'b101:  load_c = {16'd0, half_c};
            default: load_c = rword_c;
        endcase
        result_c = (err_c || i_we) ? 32'd0 : load_c;
    end

    assign wr_en_c = accept_c & i_we & ~err_c;

    // Memory array; stores commit at the accept edge and contents survive reset.
    always_ff @(posedge i_clk) begin
        if (wr_en_c) begin
            for (int i = 0; i < 4; i++) begin
                if (be_c[i]) begin
                    mem_q[idx_c][8*i +: 8] <= wlanes_c[8*i +: 8];
                end
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pipe_data_d  = pipe_data_q;
        pipe_err_d   = pipe_err_q;
        ready_d      = 1'b0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        rdata_d      = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    pipe_data_d = result_c;
                    pipe_err_d  = err_c;
                    // Stores and rejected accesses answer on the next cycle.
                    if (i_we || err_c || (READ_LATENCY == 1)) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
        if (state_d == S_RESP) begin
            resp_valid_d = 1'b1;
            // Coming straight from IDLE the pipeline register is not yet loaded.
            if (state_q == S_IDLE) begin
                rdata_d    = result_c;
                resp_err_d = err_c;
            end else begin
                rdata_d    = pipe_data_q;
                resp_err_d = pipe_err_q;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= 32'd0;
            pipe_data_q  <= 32'd0;
            pipe_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            rdata_q      <= rdata_d;
            pipe_data_q  <= pipe_data_d;
            pipe_err_q   <= pipe_err_d;
        end
    end

    assign o_ready      = ready_q;
    assign o_resp_valid = resp_valid_q;
    assign o_resp_err   = resp_err_q;
    assign o_rdata      = rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: one instance at READ_LATENCY=1, one at 3.
module tb_dmem_ctrl;

    logic        clk;
    logic        rst_n1, rst_n3;
    logic        req1, req3;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic        ready1, rv1, err1;
    logic [31:0] rdata1;
    logic        ready3, rv3, err3;
    logic [31:0] rdata3;

    int n_tests;
    int n_fail;

    dmem_ctrl #(.MEM_SIZE_KB(1), .READ_LATENCY(1)) u_dut1 (
        .i_clk        (clk),
        .i_rst_n      (rst_n1),
        .i_req        (req1),
        .i_we         (we),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .i_funct3     (funct3),
        .o_ready      (ready1),
        .o_resp_valid (rv1),
        .o_resp_err   (err1),
        .o_rdata      (rdata1)
    );

    dmem_ctrl #(.MEM_SIZE_KB(1), .READ_LATENCY(3)) u_dut3 (
        .i_clk        (clk),
        .i_rst_n      (rst_n3),
        .i_req        (req3),
        .i_we         (we),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .i_funct3     (funct3),
        .o_ready      (ready3),
        .o_resp_valid (rv3),
        .o_resp_err   (err3),
        .o_rdata      (rdata3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n1 && ready1) assert (!$isunknown(req1)) else $error("req1 unknown while ready");
        if (rst_n3 && ready3) assert (!$isunknown(req3)) else $error("req3 unknown while ready");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic cur_ready(input int sel);
        return (sel == 1) ? ready1 : ready3;
    endfunction

    function automatic logic cur_rv(input int sel);
        return (sel == 1) ? rv1 : rv3;
    endfunction

    // One transaction; lat = cycles from accept edge to o_resp_valid seen.
    task automatic txn(input int sel, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er, output int lat);
        int guard;
        @(negedge clk);
        we = w; funct3 = f3; addr = a; wdata = d;
        if (sel == 1) req1 = 1'b1; else req3 = 1'b1;
        guard = 0;
        while (!cur_ready(sel) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) check("accept_timeout", 32'(guard), 32'd0);
        @(posedge clk);
        @(negedge clk);
        req1 = 1'b0; req3 = 1'b0;
        lat = 1;
        while (!cur_rv(sel) && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        rd = (sel == 1) ? rdata1 : rdata3;
        er = (sel == 1) ? err1 : err3;
    endtask

    task automatic do_store(input int sel, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, input string tag);
        logic [31:0] rd; logic er; int lat;
        txn(sel, 1'b1, f3, a, d, rd, er, lat);
        check({tag, "_lat"}, 32'(lat), 32'd1);
        check({tag, "_err"}, {31'd0, er}, 32'd0);
    endtask

    task automatic do_load(input int sel, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] exp, input int exp_lat, input string tag);
        logic [31:0] rd; logic er; int lat;
        txn(sel, 1'b0, f3, a, 32'd0, rd, er, lat);
        check({tag, "_data"}, rd, exp);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_err"}, {31'd0, er}, 32'd0);
    endtask

    task automatic do_bad(input int sel, input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d, input string tag);
        logic [31:0] rd; logic er; int lat;
        txn(sel, w, f3, a, d, rd, er, lat);
        check({tag, "_err"}, {31'd0, er}, 32'd1);
        check({tag, "_data"}, rd, 32'd0);
        check({tag, "_lat"}, 32'(lat), 32'd1);
    endtask

    initial begin
        int acc_t[3];
        int rv_t[2];
        int n_acc;
        int n_rv;
        int guard;
        int rv_after_rst;
        logic [31:0] first_rd;

        n_tests = 0; n_fail = 0;
        rst_n1 = 1'b0; rst_n3 = 1'b0;
        req1 = 1'b0; req3 = 1'b0;
        we = 1'b0; addr = '0; wdata = '0; funct3 = '0;

        #12;
        check("rst_ready", {31'd0, ready1}, 32'd1);
        check("rst_rv",    {31'd0, rv1},    32'd0);
        check("rst_err",   {31'd0, err1},   32'd0);
        check("rst_rdata", rdata1,          32'd0);
        @(negedge clk);
        rst_n1 = 1'b1; rst_n3 = 1'b1;

        // Basic word store/load.
        do_store(1, 3'b010, 32'h10, 32'hDEADBEEF, "sw10");
        do_load (1, 3'b010, 32'h10, 32'hDEADBEEF, 1, "lw10");
        repeat (3) @(negedge clk);
        check("rdata_hold", rdata1, 32'hDEADBEEF);

        // Byte store and byte loads.
        do_store(1, 3'b010, 32'h20, 32'h0, "sw20");
        do_store(1, 3'b000, 32'h21, 32'h80, "sb21");
        do_load (1, 3'b010, 32'h20, 32'h00008000, 1, "lw20");
        do_load (1, 3'b000, 32'h21, 32'hFFFFFF80, 1, "lb21");
        do_load (1, 3'b100, 32'h21, 32'h00000080, 1, "lbu21");

        // Halfword store and halfword loads.
        do_store(1, 3'b010, 32'h30, 32'h0, "sw30");
        do_store(1, 3'b001, 32'h32, 32'h8001, "sh32");
        do_load (1, 3'b001, 32'h32, 32'hFFFF8001, 1, "lh32");
        do_load (1, 3'b101, 32'h32, 32'h00008001, 1, "lhu32");
        do_load (1, 3'b010, 32'h30, 32'h80010000, 1, "lw30");

        // Rejected accesses leave memory untouched.
        do_store(1, 3'b010, 32'h00, 32'h11223344, "sw00");
        do_store(1, 3'b010, 32'h04, 32'h55667788, "sw04");
        do_bad  (1, 1'b0, 3'b010, 32'h02, 32'h0, "lw02_mis");
        do_load (1, 3'b010, 32'h00, 32'h11223344, 1, "lw00_a");
        do_bad  (1, 1'b1, 3'b001, 32'h05, 32'hFFFF, "sh05_mis");
        do_load (1, 3'b010, 32'h04, 32'h55667788, 1, "lw04");
        do_bad  (1, 1'b0, 3'b010, 32'h400, 32'h0, "lw400_oor");
        do_bad  (1, 1'b1, 3'b010, 32'h400, 32'hAAAAAAAA, "sw400_oor");
        do_load (1, 3'b010, 32'h00, 32'h11223344, 1, "lw00_b");
        do_bad  (1, 1'b0, 3'b011, 32'h00, 32'h0, "ld011");
        do_bad  (1, 1'b1, 3'b100, 32'h00, 32'h0, "st100");
        do_load (1, 3'b010, 32'h00, 32'h11223344, 1, "lw00_c");

        // Latency 3 instance: store then load, plus read-after-write.
        do_store(3, 3'b010, 32'h40, 32'hCAFEF00D, "l3_sw40");
        do_load (3, 3'b010, 32'h40, 32'hCAFEF00D, 3, "l3_lw40");
        do_store(3, 3'b000, 32'h43, 32'h12, "l3_sb43");
        do_load (3, 3'b010, 32'h40, 32'h12FEF00D, 3, "l3_raw");

        // Back-to-back loads with request held high.
        n_acc = 0; n_rv = 0; first_rd = '0;
        @(negedge clk);
        we = 1'b0; funct3 = 3'b010; addr = 32'h40; req3 = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (rv3 && n_rv < 2) begin
                if (n_rv == 0) first_rd = rdata3;
                rv_t[n_rv] = k;
                n_rv++;
            end
            if (ready3 && n_acc < 3) begin
                acc_t[n_acc] = k;
                n_acc++;
            end
            @(negedge clk);
        end
        req3 = 1'b0;
        check("b2b_n_acc", 32'(n_acc), 32'd3);
        check("b2b_n_rv",  32'(n_rv),  32'd2);
        if (n_acc == 3 && n_rv == 2) begin
            check("b2b_gap0", 32'(acc_t[1] - acc_t[0]), 32'd4);
            check("b2b_gap1", 32'(acc_t[2] - acc_t[1]), 32'd4);
            check("b2b_lat0", 32'(rv_t[0] - acc_t[0]), 32'd3);
            check("b2b_lat1", 32'(rv_t[1] - acc_t[1]), 32'd3);
        end
        check("b2b_data", first_rd, 32'h12FEF00D);
        guard = 0;
        repeat (2) @(negedge clk);
        while (!ready3 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("b2b_drain", {31'd0, ready3}, 32'd1);
        check("pre_rst_rdata", rdata3, 32'h12FEF00D);

        // Reset one cycle after a load accept: response dropped.
        we = 1'b0; funct3 = 3'b010; addr = 32'h40; req3 = 1'b1;
        @(posedge clk);
        #1 req3 = 1'b0;
        @(posedge clk);
        #1 rst_n3 = 1'b0;
        #1;
        check("mid_rst_rdata", rdata3, 32'd0);
        check("mid_rst_rv",    {31'd0, rv3},    32'd0);
        check("mid_rst_ready", {31'd0, ready3}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n3 = 1'b1;
        rv_after_rst = 0;
        @(negedge clk);
        check("post_rst_ready", {31'd0, ready3}, 32'd1);
        for (int k = 0; k < 8; k++) begin
            if (rv3) rv_after_rst++;
            @(negedge clk);
        end
        check("post_rst_no_resp", 32'(rv_after_rst), 32'd0);
        do_load(3, 3'b010, 32'h40, 32'h12FEF00D, 3, "post_rst_mem");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "bench timeout");
    end

endmodule
